// File: rtl/fifo_stream_reader.sv
// Read-side burst engine: pulls a commanded number of words from a FIFO read port and
// presents them as a valid/ready stream with a last marker, absorbing read latency in a 2-entry buffer.
module fifo_stream_reader #(
    parameter int pDATA_WIDTH = 16,
    parameter int pFWFT       = 0,
    parameter int pLEN_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [pLEN_WIDTH-1:0]  burst_len,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   fifo_ren,
    input  logic [pDATA_WIDTH-1:0] fifo_rdata,
    input  logic                   fifo_empty,
    input  logic                   fifo_underflow,
    output logic                   m_valid,
    output logic [pDATA_WIDTH-1:0] m_data,
    output logic                   m_last,
    input  logic                   m_ready
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [pLEN_WIDTH-1:0] LEN_ONE = {{(pLEN_WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [pLEN_WIDTH-1:0]  r_remaining;
    logic                   r_inflight;
    logic                   r_inflight_last;
    logic [1:0]             r_occ;
    logic [pDATA_WIDTH-1:0] r_data0;
    logic [pDATA_WIDTH-1:0] r_data1;
    logic                   r_last0;
    logic                   r_last1;
    logic                   r_error;

    logic                   w_pop;
    logic                   w_push;
    logic                   w_push_last;
    logic                   w_inflight;
    logic                   w_issue_ok;
    logic                   w_start_ok;
    logic                   w_rem_one;
    logic [2:0]             w_level;

    assign w_inflight  = (pFWFT == 0) ? r_inflight : 1'b0;
    assign w_rem_one   = (r_remaining == LEN_ONE);
    assign w_pop       = m_valid && m_ready;
    assign w_start_ok  = (r_state == S_IDLE) && start;

    // Buffer slots committed after this cycle's pop must leave room for one more word.
    assign w_level     = {1'b0, r_occ} + {2'b00, w_inflight};
    assign w_issue_ok  = w_level < (3'd2 + {2'b00, w_pop});

    assign fifo_ren    = (r_state == S_RUN) && (r_remaining != '0) && !fifo_empty && w_issue_ok;

    // In FWFT mode the word is already on fifo_rdata when ren is raised.
    assign w_push      = (pFWFT != 0) ? fifo_ren : r_inflight;
    assign w_push_last = (pFWFT != 0) ? (fifo_ren && w_rem_one) : r_inflight_last;

    assign m_valid     = (r_occ != 2'd0);
    assign m_data      = r_data0;
    assign m_last      = m_valid && r_last0;
    assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done        = (r_state == S_DONE);
    assign error       = r_error;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = (burst_len != '0) ? S_RUN : S_DONE;
            S_RUN:   if ((r_remaining == '0) && !w_inflight) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_occ == 2'd0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_error         <= 1'b0;
            r_occ           <= 2'd0;
            r_data0         <= '0;
            r_data1         <= '0;
            r_last0         <= 1'b0;
            r_last1         <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_inflight      <= (pFWFT == 0) && fifo_ren;
            r_inflight_last <= (pFWFT == 0) && fifo_ren && w_rem_one;

            if (w_start_ok)
                r_remaining <= burst_len;
            else if (fifo_ren)
                r_remaining <= r_remaining - LEN_ONE;

            if (w_start_ok)
                r_error <= 1'b0;
            else if (busy && fifo_underflow)
                r_error <= 1'b1;

            // Slot 0 is always the head; a pop shifts slot 1 forward.
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_data0 <= fifo_rdata;
                        r_last0 <= w_push_last;
                    end else begin
                        r_data1 <= fifo_rdata;
                        r_last1 <= w_push_last;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_last0 <= r_last1;
                    r_occ   <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_data0 <= fifo_rdata;
                        r_last0 <= w_push_last;
                    end else begin
                        r_data0 <= r_data1;
                        r_last0 <= r_last1;
                        r_data1 <= fifo_rdata;
                        r_last1 <= w_push_last;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: one instance with registered FIFO reads, one with
// first-word-fall-through, each fed by a small behavioural FIFO.
module tb_fifo_stream_reader;
    logic             clk;
    logic             reset;
    logic             clr;
    logic [1:0]       start, busy, done, error, fren, fempty, undf, mvalid, mlast, mready;
    logic [1:0][15:0] blen, frdata, mdata;

    logic [15:0]      mem [2][32];
    logic [5:0]       wp [2];
    logic [5:0]       rp [2];
    logic [15:0]      rq [2];
    int               ren_cnt [2];
    int               ren_empty [2];

    int               total;
    int               bad;
    int               ren0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign fempty[g] = (wp[g] == rp[g]);
        assign frdata[g] = (g == 0) ? rq[g] : mem[g][rp[g][4:0]];

        fifo_stream_reader #(
            .pDATA_WIDTH(16),
            .pFWFT      (g),
            .pLEN_WIDTH (16)
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .start         (start[g]),
            .burst_len     (blen[g]),
            .busy          (busy[g]),
            .done          (done[g]),
            .error         (error[g]),
            .fifo_ren      (fren[g]),
            .fifo_rdata    (frdata[g]),
            .fifo_empty    (fempty[g]),
            .fifo_underflow(undf[g]),
            .m_valid       (mvalid[g]),
            .m_data        (mdata[g]),
            .m_last        (mlast[g]),
            .m_ready       (mready[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural FIFO read side plus read-enable bookkeeping.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                rp[k]        <= '0;
                ren_cnt[k]   <= 0;
                ren_empty[k] <= 0;
            end else if (fren[k]) begin
                rp[k]      <= rp[k] + 6'd1;
                rq[k]      <= mem[k][rp[k][4:0]];
                ren_cnt[k] <= ren_cnt[k] + 1;
                if (fempty[k]) ren_empty[k] <= ren_empty[k] + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input int k, input logic [15:0] d);
        mem[k][wp[k][4:0]] = d;
        wp[k] = wp[k] + 6'd1;
    endtask

    task automatic start_burst(input int k, input logic [15:0] len);
        start[k] = 1'b1;
        blen[k]  = len;
        step();
        start[k] = 1'b0;
    endtask

    task automatic drain(input int k, input int n, input logic [15:0] base, input bit toggle,
                         input int late_at, input int late_n, input int r0);
        int          got = 0;
        bit          seen = 1'b0;
        bit          prev_stall = 1'b0;
        logic [15:0] prev_d = '0;
        for (int c = 0; c < 300; c++) begin
            if (c == late_at)
                for (int j = 0; j < late_n; j++) push_word(k, base + 16'(n - late_n + j));
            mready[k] = toggle ? c[0] : 1'b1;
            if (done[k]) begin
                seen = 1'b1;
                break;
            end
            chk("busy_run", busy[k], 1);
            if (prev_stall) begin
                chk("hold_valid", mvalid[k], 1);
                chk("hold_data", mdata[k], prev_d);
            end
            chk("occ_le2", ((ren_cnt[k] - r0 - got) <= 2), 1);
            if (mvalid[k] && mready[k]) begin
                chk("word_data", mdata[k], 32'(base) + got);
                chk("word_last", mlast[k], (got == n - 1));
                got++;
            end
            prev_stall = mvalid[k] && !mready[k];
            prev_d     = mdata[k];
            step();
        end
        chk("done_seen", seen, 1);
        chk("word_cnt", got, n);
        chk("ren_cnt", ren_cnt[k] - r0, n);
        chk("ren_on_empty", ren_empty[k], 0);
        step();
        chk("done_pulse", done[k], 0);
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; clr = 1'b1;
        start = '0; undf = '0; mready = '0; blen = '0;
        wp[0] = '0; wp[1] = '0;
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy", busy[k], 0);
            chk("rst_done", done[k], 0);
            chk("rst_error", error[k], 0);
            chk("rst_ren", fren[k], 0);
            chk("rst_valid", mvalid[k], 0);
            chk("rst_last", mlast[k], 0);
            chk("rst_data", mdata[k], 0);
        end
        clr = 1'b0; reset = 1'b0;
        step();

        // Registered-read FIFO: 8-word burst at full rate.
        for (int i = 0; i < 8; i++) push_word(0, 16'(i));
        mready[0] = 1'b1;
        ren0 = ren_cnt[0];
        start_burst(0, 16'd8);
        chk("s1_busy", busy[0], 1);
        chk("s1_v_e0", mvalid[0], 0);
        step();
        chk("s1_v_e1", mvalid[0], 0);
        step();
        for (int i = 0; i < 8; i++) begin
            chk("s1_valid", mvalid[0], 1);
            chk("s1_data", mdata[0], i);
            chk("s1_last", mlast[0], (i == 7));
            step();
        end
        chk("s1_drain_v", mvalid[0], 0);
        chk("s1_drain_done", done[0], 0);
        chk("s1_drain_busy", busy[0], 1);
        step();
        chk("s1_done", done[0], 1);
        chk("s1_done_busy", busy[0], 0);
        step();
        chk("s1_done_end", done[0], 0);
        chk("s1_ren_cnt", ren_cnt[0] - ren0, 8);
        chk("s1_ren_empty", ren_empty[0], 0);

        // Consumer stalls every other cycle.
        for (int i = 0; i < 4; i++) push_word(0, 16'h0010 + 16'(i));
        ren0 = ren_cnt[0];
        start_burst(0, 16'd4);
        drain(0, 4, 16'h0010, 1'b1, -1, 0, ren0);

        // FIFO runs dry mid-burst and is refilled 20 cycles later.
        push_word(0, 16'h0020);
        push_word(0, 16'h0021);
        ren0 = ren_cnt[0];
        start_burst(0, 16'd5);
        drain(0, 5, 16'h0020, 1'b0, 20, 3, ren0);
        chk("s3_error", error[0], 0);

        // Start while busy has no effect.
        push_word(0, 16'h0040);
        push_word(0, 16'h0041);
        mready[0] = 1'b0;
        ren0 = ren_cnt[0];
        start_burst(0, 16'd2);
        step(); step(); step();
        start_burst(0, 16'd7);
        chk("s4_busy_kept", busy[0], 1);
        drain(0, 2, 16'h0040, 1'b0, -1, 0, ren0);

        // Reset after three of eight words.
        for (int i = 0; i < 8; i++) push_word(0, 16'h0050 + 16'(i));
        mready[0] = 1'b1;
        start_burst(0, 16'd8);
        step(); step(); step(); step(); step();
        chk("s5_pre_valid", mvalid[0], 1);
        chk("s5_pre_data", mdata[0], 16'h0053);
        reset = 1'b1;
        #1;
        chk("s5_rst_busy", busy[0], 0);
        chk("s5_rst_done", done[0], 0);
        chk("s5_rst_error", error[0], 0);
        chk("s5_rst_ren", fren[0], 0);
        chk("s5_rst_valid", mvalid[0], 0);
        chk("s5_rst_last", mlast[0], 0);
        chk("s5_rst_data", mdata[0], 0);
        @(negedge clk);
        reset = 1'b0;
        step();

        ren0 = ren_cnt[0];
        start_burst(0, 16'd2);
        undf[0] = 1'b1;
        step();
        undf[0] = 1'b0;
        chk("s5_err_set", error[0], 1);
        drain(0, 2, 16'h0055, 1'b0, -1, 0, ren0);
        chk("s5_err_sticky", error[0], 1);

        // Zero-length burst; its accepted start also clears the error.
        ren0 = ren_cnt[0];
        start_burst(0, 16'd0);
        chk("z_err_clr", error[0], 0);
        chk("z_done", done[0], 1);
        chk("z_busy", busy[0], 0);
        chk("z_valid", mvalid[0], 0);
        step();
        chk("z_done_end", done[0], 0);
        chk("z_valid2", mvalid[0], 0);
        chk("z_ren_cnt", ren_cnt[0] - ren0, 0);

        // First-word-fall-through FIFO: 8-word burst at full rate.
        for (int i = 0; i < 8; i++) push_word(1, 16'h0080 + 16'(i));
        mready[1] = 1'b1;
        ren0 = ren_cnt[1];
        start_burst(1, 16'd8);
        chk("f1_busy", busy[1], 1);
        chk("f1_v_e0", mvalid[1], 0);
        step();
        for (int i = 0; i < 8; i++) begin
            chk("f1_valid", mvalid[1], 1);
            chk("f1_data", mdata[1], 16'h0080 + i);
            chk("f1_last", mlast[1], (i == 7));
            step();
        end
        chk("f1_drain_v", mvalid[1], 0);
        chk("f1_drain_done", done[1], 0);
        chk("f1_drain_busy", busy[1], 1);
        step();
        chk("f1_done", done[1], 1);
        chk("f1_done_busy", busy[1], 0);
        step();
        chk("f1_done_end", done[1], 0);
        chk("f1_ren_cnt", ren_cnt[1] - ren0, 8);
        chk("f1_ren_empty", ren_empty[1], 0);

        for (int i = 0; i < 4; i++) push_word(1, 16'h0090 + 16'(i));
        ren0 = ren_cnt[1];
        start_burst(1, 16'd4);
        drain(1, 4, 16'h0090, 1'b1, -1, 0, ren0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
